// File: rtl/word_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_ser_pkg
// Description : Shared constants and FSM state encoding for word_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package word_ser_pkg;

    // Default word width delivered by the upstream byte-pair pipe
    localparam int WORD_SER_WIDTH = 16;

    // Serializer states; S_PAR is only reachable when parity is built in
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : word_ser_if
// Description : Load handshake plus serial output bundle of word_serializer.
//               master = upstream/consumer side, slave = serializer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface word_ser_if
    import word_ser_pkg::*;
#(
    parameter int WIDTH = WORD_SER_WIDTH
);
    logic [WIDTH-1:0] Data_in;
    logic             Ld;
    logic             Ack;
    logic             Ser_out;
    logic             Ser_valid;
    logic             Frame_start;
    logic             Frame_end;
    logic             Busy;

    modport master (
        output Data_in, Ld,
        input  Ack, Ser_out, Ser_valid, Frame_start, Frame_end, Busy
    );

    modport slave (
        input  Data_in, Ld,
        output Ack, Ser_out, Ser_valid, Frame_start, Frame_end, Busy
    );
endinterface
`default_nettype wire

// File: rtl/word_serializer_hold.sv
`default_nettype none
// ============================================================================
// Module      : word_hold_reg
// Description : One-entry holding register in front of the shifter. Accepts
//               a word on Ld && Ack; the shifter empties it with take.
// Revision    : 1.0 - initial release
// ============================================================================
module word_hold_reg #(
    parameter int WIDTH = 16
) (
    input  wire logic             clock,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] Data_in,
    input  wire logic             Ld,
    input  wire logic             take,
    output logic      [WIDTH-1:0] hold,
    output logic                  hold_full,
    output logic                  Ack
);

    logic [WIDTH-1:0] hold_q;
    logic             full_q;

    // Ready whenever empty; forced low during reset so nothing is captured
    assign Ack       = ~full_q & ~rst;
    assign hold      = hold_q;
    assign hold_full = full_q;

    // Capture on handshake, release when the shifter takes the word.
    // take only occurs while full (Ack low), so the two never coincide.
    always_ff @(posedge clock) begin
        if (rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (Ld && Ack) begin
            hold_q <= Data_in;
            full_q <= 1'b1;
        end else if (take) begin
            full_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_serializer
// Description : Buffers one 16-bit (WIDTH) word and shifts it out one bit per
//               clock with Frame_start/Frame_end strobes; back-to-back frames
//               stream without gaps. Optional macro WORD_SER_PAR_EN appends
//               an even-parity bit after the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
    import word_ser_pkg::*;
#(
    parameter int WIDTH     = WORD_SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic clock,
    input  wire logic rst,
    word_ser_if.slave bus
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               fstart_q, fstart_d;
    logic               fend_q, fend_d;
`ifdef WORD_SER_PAR_EN
    logic               par_q, par_d;
`endif

    logic [WIDTH-1:0]   hold;
    logic               hold_full;
    logic               take;
    logic               frame_done;
    logic               next_bit;

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock     (clock),
        .rst       (rst),
        .Data_in   (bus.Data_in),
        .Ld        (bus.Ld),
        .take      (take),
        .hold      (hold),
        .hold_full (hold_full),
        .Ack       (bus.Ack)
    );

    assign next_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

    // State, shifter, counter and registered serial outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            fstart_q    <= 1'b0;
            fend_q      <= 1'b0;
`ifdef WORD_SER_PAR_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            fstart_q    <= fstart_d;
            fend_q      <= fend_d;
`ifdef WORD_SER_PAR_EN
            par_q       <= par_d;
`endif
        end
    end

    // Next-state, bit emission and hold->shift reload decisions
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        fstart_d    = 1'b0;
        fend_d      = 1'b0;
        take        = 1'b0;
        frame_done  = 1'b0;
`ifdef WORD_SER_PAR_EN
        par_d       = par_q;
`endif

        case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
                ser_out_d   = next_bit;
                ser_valid_d = 1'b1;
                fstart_d    = (count_q == '0);
                shift_d     = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shift_q[WIDTH-1:1]};
                if (count_q == LAST_CNT) begin
`ifdef WORD_SER_PAR_EN
                    state_d    = S_PAR;
`else
                    fend_d     = 1'b1;
                    frame_done = 1'b1;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
`ifdef WORD_SER_PAR_EN
            S_PAR: begin
                ser_out_d   = par_q;
                ser_valid_d = 1'b1;
                fend_d      = 1'b1;
                frame_done  = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (frame_done) begin
            state_d = S_IDLE;
        end

        // Reload while idle, or on the last frame bit for gapless streaming
        if (hold_full && ((state_q == S_IDLE) || frame_done)) begin
            state_d = S_SHIFT;
            shift_d = hold;
            count_d = '0;
            take    = 1'b1;
`ifdef WORD_SER_PAR_EN
            par_d   = ^hold;
`endif
        end
    end

    assign bus.Ser_out     = ser_out_q;
    assign bus.Ser_valid   = ser_valid_q;
    assign bus.Frame_start = fstart_q;
    assign bus.Frame_end   = fend_q;
    assign bus.Busy        = (state_q != S_IDLE) | hold_full | ser_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_serializer
// Description : Self-checking bench for word_serializer. Drives an MSB-first
//               and an LSB-first instance with the same stimulus and checks
//               both against a queue-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_serializer;
    import word_ser_pkg::*;

    localparam int W = 16;
`ifdef WORD_SER_PAR_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = W + PAR;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic [W-1:0] data_tb = '0;
    logic         ld_tb   = 1'b0;

    always #5 clock = ~clock;

    word_ser_if #(.WIDTH(W)) bus_m ();
    word_ser_if #(.WIDTH(W)) bus_l ();

    assign bus_m.Data_in = data_tb;
    assign bus_m.Ld      = ld_tb;
    assign bus_l.Data_in = data_tb;
    assign bus_l.Ld      = ld_tb;

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_m)
    );

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_l)
    );

    // One expected output cycle: bit for each order plus the strobes
    typedef struct packed {
        logic bm;
        logic bl;
        logic fs;
        logic fe;
    } rec_t;

    rec_t         stream[$];
    logic         hold_full_m = 1'b0;
    logic [W-1:0] hold_m      = '0;
    rec_t         exp_r       = '0;
    logic         exp_v       = 1'b0;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           fs_cyc = 0;
    int           run = 0;
    int           max_run = 0;
    logic         accepted = 1'b0;
    logic [31:0]  cap_m = '0, cap_l = '0, last_m = '0, last_l = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected frame as a left-to-right bit string in transmit order
    function automatic logic [31:0] frame_bits(input logic [W-1:0] w, input bit lsb);
        logic [31:0] v = '0;
        for (int i = 0; i < W; i++) begin
            v = {v[30:0], (lsb ? w[i] : w[W-1-i])};
        end
        if (PAR != 0) v = {v[30:0], ^w};
        return v;
    endfunction

    function automatic void push_frame(input logic [W-1:0] w);
        rec_t r;
        for (int i = 0; i < W; i++) begin
            r.bm = w[W-1-i];
            r.bl = w[i];
            r.fs = (i == 0);
            r.fe = (PAR == 0) && (i == W - 1);
            stream.push_back(r);
        end
        if (PAR != 0) begin
            r.bm = ^w;
            r.bl = ^w;
            r.fs = 1'b0;
            r.fe = 1'b1;
            stream.push_back(r);
        end
    endfunction

    // Advance one clock: check Ack before the edge, advance the model at the
    // edge, check all outputs of both instances on the falling edge.
    task automatic cycle();
        logic ackexp;
        logic acc;
        logic busy_exp;
        #1;
        ackexp = !hold_full_m && !rst;
        chk("ack_msb", {31'd0, bus_m.Ack}, {31'd0, ackexp});
        chk("ack_lsb", {31'd0, bus_l.Ack}, {31'd0, ackexp});
        acc      = ld_tb && ackexp;
        accepted = acc;
        @(posedge clock);
        cyc++;
        if (rst) begin
            stream.delete();
            hold_full_m = 1'b0;
            exp_r       = '0;
            exp_v       = 1'b0;
        end else begin
            if (stream.size() > 0) begin
                exp_r = stream.pop_front();
                exp_v = 1'b1;
            end else begin
                exp_r = '0;
                exp_v = 1'b0;
            end
            if (stream.size() == 0 && hold_full_m) begin
                push_frame(hold_m);
                hold_full_m = 1'b0;
            end
            if (acc) begin
                hold_m      = data_tb;
                hold_full_m = 1'b1;
            end
        end
        busy_exp = (stream.size() > 0) || hold_full_m || exp_v;
        @(negedge clock);
        chk("valid_msb", {31'd0, bus_m.Ser_valid},   {31'd0, exp_v});
        chk("valid_lsb", {31'd0, bus_l.Ser_valid},   {31'd0, exp_v});
        chk("out_msb",   {31'd0, bus_m.Ser_out},     {31'd0, exp_r.bm});
        chk("out_lsb",   {31'd0, bus_l.Ser_out},     {31'd0, exp_r.bl});
        chk("fs_msb",    {31'd0, bus_m.Frame_start}, {31'd0, exp_r.fs});
        chk("fs_lsb",    {31'd0, bus_l.Frame_start}, {31'd0, exp_r.fs});
        chk("fe_msb",    {31'd0, bus_m.Frame_end},   {31'd0, exp_r.fe});
        chk("fe_lsb",    {31'd0, bus_l.Frame_end},   {31'd0, exp_r.fe});
        chk("busy_msb",  {31'd0, bus_m.Busy},        {31'd0, busy_exp});
        chk("busy_lsb",  {31'd0, bus_l.Busy},        {31'd0, busy_exp});
        if (bus_m.Ser_valid) begin
            if (bus_m.Frame_start) begin
                cap_m  = '0;
                fs_cyc = cyc;
            end
            cap_m = {cap_m[30:0], bus_m.Ser_out};
            if (bus_m.Frame_end) last_m = cap_m;
            run++;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        if (bus_l.Ser_valid) begin
            if (bus_l.Frame_start) cap_l = '0;
            cap_l = {cap_l[30:0], bus_l.Ser_out};
            if (bus_l.Frame_end) last_l = cap_l;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Hold Ld with a word until the handshake completes (bounded)
    task automatic send(input logic [W-1:0] w);
        int n = 0;
        ld_tb    = 1'b1;
        data_tb  = w;
        accepted = 1'b0;
        while (!accepted && n < 100) begin
            cycle();
            n++;
        end
        chk("send_accepted", {31'd0, accepted}, 32'd1);
        acc_cyc = cyc;
        ld_tb   = 1'b0;
        data_tb = W'($urandom);
    endtask

    initial begin
        // Reset state
        idle(3);
        rst = 1'b0;

        // Single word, spec pattern and 2-cycle latency
        send(16'h5655);
        idle(FLEN + 4);
        chk("spec_5655_data", last_m >> PAR, 32'h5655);
        if (PAR != 0) chk("spec_5655_par", {31'd0, last_m[0]}, 32'd0);
        chk("frame_5655_lsb", last_l, frame_bits(16'h5655, 1'b1));
        chk("latency", 32'(fs_cyc - acc_cyc), 32'd2);

        // Parity-sensitive word and frame length
        max_run = 0;
        send(16'h0001);
        idle(FLEN + 4);
        chk("frame_0001_msb", last_m, frame_bits(16'h0001, 1'b0));
        chk("frame_len", 32'(max_run), 32'(FLEN));

        // LSB first: 1, fourteen 0s, 1
        send(16'h8001);
        idle(FLEN + 4);
        chk("spec_8001_lsb", last_l >> PAR, 32'h8001);

        // Back-to-back with backpressure on the second word
        max_run = 0;
        send(16'hAAAA);
        chk("bp_ack_low", {31'd0, bus_m.Ack}, 32'd0);
        send(16'h5555);
        idle(2 * FLEN + 4);
        chk("b2b_run", 32'(max_run), 32'(2 * FLEN));
        chk("b2b_last", last_m, frame_bits(16'h5555, 1'b0));

        // Reset mid-frame with a word waiting in hold
        send(16'h1234);
        send(16'hBEEF);
        idle(6);
        rst = 1'b1;
        cycle();
        chk("midrst_valid", {31'd0, bus_m.Ser_valid}, 32'd0);
        chk("midrst_busy",  {31'd0, bus_m.Busy},      32'd0);
        chk("midrst_fe",    {31'd0, bus_m.Frame_end}, 32'd0);
        rst = 1'b0;
        idle(FLEN + 4);
        send(16'h0F0F);
        idle(FLEN + 4);
        chk("post_rst_frame", last_m, frame_bits(16'h0F0F, 1'b0));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            ld_tb   = ($urandom_range(0, 2) != 0);
            data_tb = W'($urandom);
            rst     = ($urandom_range(0, 120) == 0);
            cycle();
        end
        rst   = 1'b0;
        ld_tb = 1'b0;
        idle(2 * FLEN + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
